// File: rtl/vga_mem_pkg.sv
// rtl/vga_mem_pkg.sv - shared memory-bus types and pin levels for the VGA framebuffer path
package vga_mem_pkg;

  localparam int MEM_AW = 23;
  localparam int MEM_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RECOVER = 2'd3
  } psram_state_e;

  // Idle pin levels: strobes are active-low, async mode ties RAM control pins low.
  localparam logic STROBE_OFF   = 1'b1;
  localparam logic RAM_CTRL_LVL = 1'b0;
  localparam logic FLASH_DESEL  = 1'b1;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/psram_cycle_timer.sv
// rtl/psram_cycle_timer.sv - loadable down-counter that flags when a phase has run its cycles
module psram_cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/psram_async_ctrl.sv
// rtl/psram_async_ctrl.sv - async-mode cellular RAM controller: one word per request, registered strobes
module psram_async_ctrl
  import vga_mem_pkg::*;
#(
  parameter int RD_CYCLES   = 4,
  parameter int WR_CYCLES   = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [MEM_AW-1:0] req_addr,
  input  logic [MEM_DW-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [MEM_DW-1:0] rsp_data,
  output logic [MEM_AW-1:0] MemAdr,
  input  logic [MEM_DW-1:0] mem_db_in,
  output logic [MEM_DW-1:0] mem_db_out,
  output logic              mem_db_oe,
  output logic              MemOE,
  output logic              MemWR,
  output logic              RamCS,
  output logic              RamAdv,
  output logic              RamClk,
  output logic              RamCRE,
  output logic              RamLB,
  output logic              RamUB,
  output logic              FlashCS,
  output logic              FlashRp
);

  localparam int CW = cnt_width(RD_CYCLES, WR_CYCLES, TURN_CYCLES);
  localparam logic [CW-1:0] RD_LOAD   = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LOAD   = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYCLES - 1);

  psram_state_e      r_state;
  logic [MEM_AW-1:0] r_mem_adr;
  logic [MEM_DW-1:0] r_db_out;
  logic              r_db_oe;
  logic              r_ram_cs;
  logic              r_mem_oe;
  logic              r_mem_wr;
  logic              r_rsp_valid;
  logic [MEM_DW-1:0] r_rsp_data;

  logic              w_accept;
  logic              w_load;
  logic [CW-1:0]     w_load_val;
  logic              w_done;

  assign req_ready = (r_state == ST_IDLE);
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load     = 1'b1;
          w_load_val = req_we ? WR_LOAD : RD_LOAD;
        end
      end
      ST_READ, ST_WRITE: begin
        if (w_done) begin
          w_load     = 1'b1;
          w_load_val = TURN_LOAD;
        end
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = '0;
      end
    endcase
  end

  psram_cycle_timer #(
    .W (CW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mem_adr   <= '0;
      r_db_out    <= '0;
      r_db_oe     <= 1'b0;
      r_ram_cs    <= STROBE_OFF;
      r_mem_oe    <= STROBE_OFF;
      r_mem_wr    <= STROBE_OFF;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mem_adr <= req_addr;
            r_ram_cs  <= 1'b0;
            if (req_we) begin
              r_state  <= ST_WRITE;
              r_mem_wr <= 1'b0;
              r_db_oe  <= 1'b1;
              r_db_out <= req_wdata;
            end else begin
              r_state  <= ST_READ;
              r_mem_oe <= 1'b0;
            end
          end
        end
        ST_READ: begin
          if (w_done) begin
            r_rsp_data  <= mem_db_in;
            r_rsp_valid <= 1'b1;
            r_ram_cs    <= STROBE_OFF;
            r_mem_oe    <= STROBE_OFF;
            r_state     <= ST_RECOVER;
          end
        end
        ST_WRITE: begin
          // Bus drive is left on here so data is held past the MemWR rising edge.
          if (w_done) begin
            r_ram_cs <= STROBE_OFF;
            r_mem_wr <= STROBE_OFF;
            r_state  <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          r_db_oe <= 1'b0;
          if (w_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign MemAdr     = r_mem_adr;
  assign mem_db_out = r_db_out;
  assign mem_db_oe  = r_db_oe;
  assign RamCS      = r_ram_cs;
  assign MemOE      = r_mem_oe;
  assign MemWR      = r_mem_wr;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;

  assign RamAdv  = RAM_CTRL_LVL;
  assign RamClk  = RAM_CTRL_LVL;
  assign RamCRE  = RAM_CTRL_LVL;
  assign RamLB   = RAM_CTRL_LVL;
  assign RamUB   = RAM_CTRL_LVL;
  assign FlashCS = FLASH_DESEL;
  assign FlashRp = FLASH_DESEL;

endmodule

// File: tb/tb_psram_async_ctrl.sv
// tb/tb_psram_async_ctrl.sv - self-checking bench for psram_async_ctrl with a timed RAM bus model
`timescale 1ns/1ps
module tb_psram_async_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_we    [2];
  logic [22:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_data  [2];
  logic [22:0] MemAdr    [2];
  logic [15:0] mem_db_out[2];
  logic        mem_db_oe [2];
  logic        MemOE [2], MemWR [2], RamCS [2];
  logic        RamAdv [2], RamClk [2], RamCRE [2], RamLB [2], RamUB [2];
  logic        FlashCS [2], FlashRp [2];
  logic [15:0] mem_db_in0, mem_db_in1;

  int checks = 0;
  int errors = 0;
  int ovl0 = 0, ovl1 = 0;
  logic [15:0] bus_mem [int];
  logic [15:0] ref_mem [int];

  always #10 clk = ~clk;

  psram_async_ctrl u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .MemAdr(MemAdr[0]),
    .mem_db_in(mem_db_in0), .mem_db_out(mem_db_out[0]), .mem_db_oe(mem_db_oe[0]),
    .MemOE(MemOE[0]), .MemWR(MemWR[0]), .RamCS(RamCS[0]), .RamAdv(RamAdv[0]),
    .RamClk(RamClk[0]), .RamCRE(RamCRE[0]), .RamLB(RamLB[0]), .RamUB(RamUB[0]),
    .FlashCS(FlashCS[0]), .FlashRp(FlashRp[0])
  );

  psram_async_ctrl #(.RD_CYCLES(1), .WR_CYCLES(1), .TURN_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .MemAdr(MemAdr[1]),
    .mem_db_in(mem_db_in1), .mem_db_out(mem_db_out[1]), .mem_db_oe(mem_db_oe[1]),
    .MemOE(MemOE[1]), .MemWR(MemWR[1]), .RamCS(RamCS[1]), .RamAdv(RamAdv[1]),
    .RamClk(RamClk[1]), .RamCRE(RamCRE[1]), .RamLB(RamLB[1]), .RamUB(RamUB[1]),
    .FlashCS(FlashCS[1]), .FlashRp(FlashRp[1])
  );

  // Unwritten RAM words hold an address-derived pattern.
  function automatic logic [15:0] dflt(input int key);
    logic [31:0] k;
    k = key;
    return k[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] bus_rd(input int key);
    return bus_mem.exists(key) ? bus_mem[key] : dflt(key);
  endfunction

  function automatic logic [15:0] ref_rd(input int key);
    return ref_mem.exists(key) ? ref_mem[key] : dflt(key);
  endfunction

  function automatic int mkey(input int s, input logic [22:0] a);
    return s * (1 << 23) + int'(a);
  endfunction

  // Async RAM: data valid th ns after CS/OE fall, write latched on MemWR rising edge.
  task automatic bus_model(input int g, input int th);
    int cnt;
    logic prev_wr;
    logic [15:0] v;
    int key;
    cnt = 0;
    prev_wr = 1'b1;
    #0.5;
    forever begin
      #1;
      key = mkey(g, MemAdr[g]);
      if (RamCS[g] === 1'b0 && MemOE[g] === 1'b0) cnt++; else cnt = 0;
      v = (cnt >= th) ? bus_rd(key) : 16'hDEAD;
      if (g == 0) mem_db_in0 = v; else mem_db_in1 = v;
      if (prev_wr === 1'b0 && MemWR[g] === 1'b1 && mem_db_oe[g] === 1'b1) bus_mem[key] = mem_db_out[g];
      if (MemOE[g] === 1'b0 && (MemWR[g] === 1'b0 || mem_db_oe[g] === 1'b1)) begin
        if (g == 0) ovl0++; else ovl1++;
      end
      prev_wr = MemWR[g];
    end
  endtask

  initial bus_model(0, 70);
  initial bus_model(1, 10);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic access(input int s, input bit we, input logic [22:0] a, input logic [15:0] d);
    int len, n, busy, cs_lo, oe_lo, wr_lo, dboe, rv, key;
    bit adr_ok;
    logic [15:0] got, exp_d, rsp_before;
    len = (s == 0) ? 4 : 1;
    key = mkey(s, a);
    exp_d = ref_rd(key);
    busy = 0; cs_lo = 0; oe_lo = 0; wr_lo = 0; dboe = 0; rv = 0; adr_ok = 1'b1; got = '0;
    @(negedge clk);
    for (n = 0; n < 50 && !req_ready[s]; n++) @(negedge clk);
    if (!req_ready[s]) begin
      checks++; errors++;
      $display("FAIL ready_timeout s%0d: req_ready=%0b want 1", s, req_ready[s]);
      return;
    end
    rsp_before = rsp_data[s];
    req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = a; req_wdata[s] = d;
    @(negedge clk);
    req_valid[s] = 1'b0;
    for (n = 0; n < 40 && !req_ready[s]; n++) begin
      busy++;
      if (!RamCS[s]) begin cs_lo++; if (MemAdr[s] !== a) adr_ok = 1'b0; end
      if (!MemOE[s]) oe_lo++;
      if (!MemWR[s]) wr_lo++;
      if (mem_db_oe[s]) dboe++;
      if (rsp_valid[s]) begin rv++; got = rsp_data[s]; end
      @(negedge clk);
    end
    checks++; if (busy !== len + 1) begin errors++; $display("FAIL period s%0d we%0b: got %0d want %0d", s, we, busy, len + 1); end
    checks++; if (cs_lo !== len) begin errors++; $display("FAIL cs_low s%0d we%0b: got %0d want %0d", s, we, cs_lo, len); end
    checks++; if (oe_lo !== (we ? 0 : len)) begin errors++; $display("FAIL oe_low s%0d we%0b: got %0d want %0d", s, we, oe_lo, we ? 0 : len); end
    checks++; if (wr_lo !== (we ? len : 0)) begin errors++; $display("FAIL wr_low s%0d we%0b: got %0d want %0d", s, we, wr_lo, we ? len : 0); end
    checks++; if (dboe !== (we ? len + 1 : 0)) begin errors++; $display("FAIL db_oe s%0d we%0b: got %0d want %0d", s, we, dboe, we ? len + 1 : 0); end
    checks++; if (rv !== (we ? 0 : 1)) begin errors++; $display("FAIL rsp_count s%0d we%0b: got %0d want %0d", s, we, rv, we ? 0 : 1); end
    checks++; if (!adr_ok) begin errors++; $display("FAIL mem_adr s%0d: got %h want %h", s, MemAdr[s], a); end
    if (we) begin
      checks++; if (bus_rd(key) !== d) begin errors++; $display("FAIL bus_write s%0d a=%h: got %h want %h", s, a, bus_rd(key), d); end
      checks++; if (rsp_data[s] !== rsp_before) begin errors++; $display("FAIL rsp_hold s%0d: got %h want %h", s, rsp_data[s], rsp_before); end
      ref_mem[key] = d;
    end else begin
      checks++; if (got !== exp_d) begin errors++; $display("FAIL rd_data s%0d a=%h: got %h want %h", s, a, got, exp_d); end
    end
  endtask

  task automatic test_reset;
    for (int s = 0; s < 2; s++) begin
      checks++; if ({MemOE[s], MemWR[s], RamCS[s], mem_db_oe[s]} !== 4'b1110) begin errors++;
        $display("FAIL reset_strobes s%0d: got %b want 1110", s, {MemOE[s], MemWR[s], RamCS[s], mem_db_oe[s]}); end
      checks++; if (MemAdr[s] !== 23'd0 || mem_db_out[s] !== 16'd0) begin errors++;
        $display("FAIL reset_bus s%0d: adr %h dout %h want 0 0", s, MemAdr[s], mem_db_out[s]); end
      checks++; if (rsp_valid[s] !== 1'b0 || rsp_data[s] !== 16'd0) begin errors++;
        $display("FAIL reset_rsp s%0d: valid %b data %h want 0 0", s, rsp_valid[s], rsp_data[s]); end
      checks++; if ({RamAdv[s], RamClk[s], RamCRE[s], RamLB[s], RamUB[s], FlashCS[s], FlashRp[s]} !== 7'b0000011) begin errors++;
        $display("FAIL const_pins s%0d: got %b want 0000011", s, {RamAdv[s], RamClk[s], RamCRE[s], RamLB[s], RamUB[s], FlashCS[s], FlashRp[s]}); end
    end
    reset = 1'b0;
    #1;
    checks++; if (req_ready[0] !== 1'b1 || req_ready[1] !== 1'b1) begin errors++;
      $display("FAIL ready_after_reset: got %b%b want 11", req_ready[0], req_ready[1]); end
  endtask

  task automatic test_read_basic;
    bus_mem[mkey(0, 23'h000123)] = 16'hBEEF;
    ref_mem[mkey(0, 23'h000123)] = 16'hBEEF;
    access(0, 1'b0, 23'h000123, 16'h0000);
  endtask

  task automatic test_write_basic;
    access(0, 1'b1, 23'h7FFFFF, 16'hA5A5);
    access(0, 1'b0, 23'h7FFFFF, 16'h0000);
  endtask

  task automatic test_write_read;
    logic [22:0] a;
    logic [15:0] d;
    for (int i = 0; i < 3; i++) begin
      a = 23'($urandom); d = 16'($urandom);
      access(0, 1'b1, a, d);
      access(0, 1'b0, a, 16'h0000);
    end
  endtask

  task automatic test_back_to_back;
    int acc[$];
    logic [15:0] exp_q[$];
    logic [15:0] e;
    int lo, rsp_n;
    bit drop, newa;
    logic [22:0] a;
    lo = 0; rsp_n = 0; drop = 0; newa = 0;
    @(negedge clk);
    a = 23'($urandom);
    req_we[0] = 1'b0; req_addr[0] = a; req_valid[0] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (newa) begin a = 23'($urandom); req_addr[0] = a; newa = 0; end
      if (drop) begin req_valid[0] = 1'b0; drop = 0; end
      if (rsp_valid[0]) begin
        rsp_n++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++; if (rsp_data[0] !== e) begin errors++; $display("FAIL b2b_data: got %h want %h", rsp_data[0], e); end
      end
      if (req_valid[0] && req_ready[0]) begin
        acc.push_back(n);
        exp_q.push_back(ref_rd(mkey(0, a)));
        newa = 1;
        if (acc.size() == 3) drop = 1;
      end else if (!req_ready[0] && acc.size() > 0 && acc.size() < 3) begin
        lo++;
      end
      @(negedge clk);
    end
    checks++; if (acc.size() !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", acc.size()); end
    if (acc.size() >= 3) begin
      checks++; if (acc[1] - acc[0] !== 6 || acc[2] - acc[1] !== 6) begin errors++;
        $display("FAIL b2b_spacing: got %0d,%0d want 6,6", acc[1] - acc[0], acc[2] - acc[1]); end
    end
    checks++; if (lo !== 10) begin errors++; $display("FAIL b2b_ready_low: got %0d want 10", lo); end
    checks++; if (rsp_n !== 3) begin errors++; $display("FAIL b2b_rsp_count: got %0d want 3", rsp_n); end
  endtask

  task automatic test_reset_mid;
    int rv;
    rv = 0;
    @(negedge clk);
    for (int n = 0; n < 20 && !req_ready[0]; n++) @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 23'h000456;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (RamCS[0] !== 1'b0) begin errors++; $display("FAIL mid_pre_cs: got %b want 0", RamCS[0]); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({RamCS[0], MemOE[0], MemWR[0], mem_db_oe[0]} !== 4'b1110) begin errors++;
      $display("FAIL mid_async_strobes: got %b want 1110", {RamCS[0], MemOE[0], MemWR[0], mem_db_oe[0]}); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", req_ready[0]); end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rsp_valid[0]) rv++;
    end
    checks++; if (rv !== 0) begin errors++; $display("FAIL mid_no_rsp: got %0d pulses want 0", rv); end
  endtask

  task automatic test_fast_param;
    logic [22:0] a;
    logic [15:0] d;
    for (int i = 0; i < 4; i++) begin
      a = 23'($urandom); d = 16'($urandom);
      access(1, 1'b1, a, d);
      access(1, 1'b0, a, 16'h0000);
    end
    access(1, 1'b0, 23'h000000, 16'h0000);
  endtask

  task automatic test_random;
    logic [22:0] a;
    for (int i = 0; i < 12; i++) begin
      // Small address window so reads often hit earlier writes.
      a = 23'($urandom_range(0, 7)) | ((i % 3 == 0) ? 23'h7FFFF8 : 23'h0);
      access(i % 2, 1'($urandom), a, 16'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0; req_wdata[s] = '0;
    end
    repeat (3) @(negedge clk);
    test_reset;
    test_read_basic;
    test_write_basic;
    test_back_to_back;
    test_write_read;
    test_reset_mid;
    test_fast_param;
    test_random;
    checks++; if (ovl0 + ovl1 !== 0) begin errors++; $display("FAIL oe_overlap: got %0d samples want 0", ovl0 + ovl1); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
